// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares a single request/grant/response memory port between instruction fetch
// and the data stage, data first, with one transaction outstanding at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                dm_stall,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e         r_state;
    arb_owner_e         r_owner;
    logic               r_discard;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [BE_W-1:0]    r_mem_be;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;

    logic               w_complete;
    logic               w_flush_own;

    assign w_complete  = (r_state == ST_WAIT) && mem_rvalid;
    assign w_flush_own = if_flush && (r_owner == OWN_IF) && (r_state != ST_IDLE);

    // A flush landing on the completion cycle also kills the stale instruction.
    assign if_valid = w_complete && (r_owner == OWN_IF) && !r_discard && !if_flush;
    assign dm_valid = w_complete && (r_owner == OWN_DM);
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_discard   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_discard <= 1'b0;
                    if (dm_req) begin
                        r_owner     <= OWN_DM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_be    <= dm_be;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_state     <= ST_REQ;
                    end else if (if_req && !if_flush) begin
                        r_owner    <= OWN_IF;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_be   <= {BE_W{1'b1}};
                        r_mem_addr <= if_addr;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_flush_own) begin
                        r_discard <= 1'b1;
                    end
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_discard <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_flush_own) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, width of all data ports; byte-enable width is DATA_W/8.
REQ-003 SHALL have ports clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have ports rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have fetch-side ports:
- if_req, input, 1, fetch request.
- if_addr, input, ADDR_W, fetch PC.
- if_flush, input, 1, redirect from branch or jump.
- if_rdata, output, DATA_W, instruction.
- if_valid, output, 1, one-cycle instruction-valid pulse.
- if_stall, output, 1, fetch stall.
REQ-006 SHALL have data-side ports:
- dm_req, input, 1, load or store request.
- dm_we, input, 1, store.
- dm_be, input, DATA_W/8, byte enables.
- dm_addr, input, ADDR_W, data address.
- dm_wdata, input, DATA_W, store data.
- dm_rdata, output, DATA_W, load data.
- dm_valid, output, 1, one-cycle completion pulse.
- dm_stall, output, 1, memory-stage stall.
REQ-007 SHALL have memory-side ports:
- mem_req, output, 1, registered request.
- mem_we, output, 1, registered write enable.
- mem_be, output, DATA_W/8, registered byte enables.
- mem_addr, output, ADDR_W, registered address.
- mem_wdata, output, DATA_W, registered write data.
- mem_gnt, input, 1, request accepted.
- mem_rvalid, input, 1, response valid.
- mem_rdata, input, DATA_W, response data.

Function
REQ-008 SHALL share one memory port between fetch and data requesters, with at most one transaction outstanding.
REQ-009 SHALL use FSM states IDLE, REQ (mem_req held, awaiting mem_gnt) and WAIT (awaiting mem_rvalid), plus an owner register (IF or DM).
REQ-010 IDLE SHALL behave as follows:
- dm_req=1 → latch dm_* fields, owner=DM, go to REQ.
- else if_req=1 and if_flush=0 → latch if_addr with mem_we=0, mem_be all ones, owner=IF, go to REQ.
- else stay in IDLE.
REQ-011 SHALL use fixed priority, data over fetch, when both request in the same IDLE cycle.
REQ-012 SHALL hold mem_req=1 and the mem_* fields stable in REQ until the cycle mem_gnt=1, then deassert mem_req and go to WAIT.
REQ-013 SHALL ignore mem_rvalid outside WAIT; the memory returns mem_rvalid at least one cycle after mem_gnt.
REQ-014 SHALL, in WAIT with mem_rvalid=1, return to IDLE and pulse the owner's valid for that cycle, with rdata driven combinationally from mem_rdata.
REQ-015 SHALL give a minimum latency of 3 cycles: request sampled in cycle N, mem_req=1 in N+1, mem_gnt at N+1 earliest, valid at N+2 earliest.
REQ-016 SHALL drive if_stall = if_req & ~if_valid and dm_stall = dm_req & ~dm_valid, both combinational.
REQ-017 SHALL set a discard flag when if_flush=1 while owner=IF in REQ or WAIT; the transaction completes on the memory side, if_valid stays 0, and the flag clears on return to IDLE.
REQ-018 SHALL give if_flush in IDLE precedence over if_req (no fetch issued that cycle); if_flush SHALL have no effect on a DM-owned transaction.
REQ-019 SHALL require dm_req and dm_* to remain stable until dm_valid; a DM transaction is not cancellable.
REQ-020 SHALL pulse dm_valid on store completion as for loads, with dm_rdata don't-care.
REQ-021 SHALL accept a new request in the IDLE cycle immediately following a completion, with no dead cycle beyond the return to IDLE.

Reset
REQ-022 SHALL, on rst_n=0 at any time including mid-transaction, asynchronously force FSM=IDLE, owner=IF, discard=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-023 SHALL hold if_valid=0 and dm_valid=0 during reset; the memory is reset in the same domain, so no stale response is expected after reset.

Structure
REQ-024 SHALL place the FSM state enum, owner enum and default widths in package mem_arb_pkg.
REQ-025 SHALL be a single module with no sub-modules; the arbitration is too small to justify a split.

Verification
REQ-026 Fetch alone: if_req=1, if_addr=0x100, gnt immediately, rvalid 1 cycle later with 0x00500093 → if_valid pulse at cycle 2 with if_rdata=0x00500093, if_stall=1 in cycles 0-1.
REQ-027 Contention: if_req=1 and dm_req=1 (load, addr 0x2000) in the same cycle → DM issued first, dm_valid, then fetch issued in the next IDLE; if_stall is held throughout.
REQ-028 Backpressure: mem_gnt held low 4 cycles → mem_req/mem_addr stable all 4 cycles, one transaction only.
REQ-029 Flush: if_flush=1 during fetch WAIT for 0x104 → no if_valid for 0x104, next fetch 0x200 issues after completion.
REQ-030 Store: dm_we=1, dm_be=0x3, dm_addr=0x2004, dm_wdata=0xDEADBEEF → mem_* carries these exact values, dm_valid pulses once.
REQ-031 Reset mid-WAIT: rst_n low in WAIT → mem_req=0 and FSM=IDLE immediately, no valid pulses; fetch resumes normally after release.
